// File: rtl/parity_acc_arbiter_if.sv
// Bundle between the two serial requesters and the shared parity accumulator.
// master = requester side, slave = arbiter side.
interface parity_acc_arbiter_if;
  logic req0;
  logic req1;
  logic x0;
  logic y0;
  logic v0;
  logic x1;
  logic y1;
  logic v1;
  logic gnt0;
  logic gnt1;
  logic parity;
  logic parity_valid;
  logic owner;
  logic abort;

  modport master (
    output req0, req1, x0, y0, v0, x1, y1, v1,
    input  gnt0, gnt1, parity, parity_valid, owner, abort
  );

  modport slave (
    input  req0, req1, x0, y0, v0, x1, y1, v1,
    output gnt0, gnt1, parity, parity_valid, owner, abort
  );
endinterface

// File: rtl/parity_acc_arbiter.sv
// Round-robin share of one XOR-parity accumulator; result strobes one cycle after the final beat edge.
// Latency: req -> gnt one edge; stalls (v=0) hold acc and cnt; owner req drop aborts the frame.
// Optional PARITY_ACC_TIMEOUT_EN: TIMEOUT consecutive stall edges abort the frame like a req drop.
module parity_acc_arbiter #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4,
  parameter int TIMEOUT   = 16
) (
  input logic                 clk,
  input logic                 reset,
  parity_acc_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t             state, state_n;
  logic               acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               last_owner, last_owner_n;
  logic               owner_q, owner_n;
  logic               gnt0_q, gnt0_n;
  logic               gnt1_q, gnt1_n;
  logic               parity_q, parity_n;
  logic               pv_q, pv_n;
  logic               abort_q, abort_n;

  logic any_req;
  logic winner;
  logic req_own;
  logic x_own;
  logic y_own;
  logic v_own;
  logic last_beat;
  logic timeout_hit;

  assign any_req   = bus.req0 | bus.req1;
  // On contention the requester that did not own the last frame wins.
  assign winner    = (bus.req0 & bus.req1) ? ~last_owner : bus.req1;
  assign req_own   = owner_q ? bus.req1 : bus.req0;
  assign x_own     = owner_q ? bus.x1   : bus.x0;
  assign y_own     = owner_q ? bus.y1   : bus.y0;
  assign v_own     = owner_q ? bus.v1   : bus.v0;
  assign last_beat = (cnt == CNT_W'(FRAME_LEN - 1));

`ifdef PARITY_ACC_TIMEOUT_EN
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;

  assign timeout_hit = (state == S_ACCUM) && !v_own &&
                       (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_comb begin
    idle_cnt_n = '0;
    if (state == S_ACCUM && !v_own) begin
      idle_cnt_n = idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_n;
    end
  end
`else
  // Constant 0: a stalled owner keeps the grant indefinitely.
  assign timeout_hit = (IDLE_W == 0);
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      acc        <= 1'b0;
      cnt        <= '0;
      last_owner <= 1'b1;
      owner_q    <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      parity_q   <= 1'b0;
      pv_q       <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      last_owner <= last_owner_n;
      owner_q    <= owner_n;
      gnt0_q     <= gnt0_n;
      gnt1_q     <= gnt1_n;
      parity_q   <= parity_n;
      pv_q       <= pv_n;
      abort_q    <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_n = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (!req_own || timeout_hit) begin
          state_n = S_IDLE;
        end else if (v_own && last_beat) begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values for the datapath and registered outputs.
  always_comb begin
    acc_n        = acc;
    cnt_n        = cnt;
    last_owner_n = last_owner;
    owner_n      = owner_q;
    gnt0_n       = gnt0_q;
    gnt1_n       = gnt1_q;
    parity_n     = parity_q;
    pv_n         = 1'b0;
    abort_n      = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          gnt0_n  = ~winner;
          gnt1_n  = winner;
          owner_n = winner;
          acc_n   = 1'b0;
          cnt_n   = '0;
        end
      end
      S_ACCUM: begin
        // A req drop wins over a final beat on the same edge.
        if (!req_own || timeout_hit) begin
          gnt0_n       = 1'b0;
          gnt1_n       = 1'b0;
          abort_n      = 1'b1;
          last_owner_n = owner_q;
        end else if (v_own) begin
          acc_n = acc ^ x_own ^ y_own;
          cnt_n = cnt + 1'b1;
          if (last_beat) begin
            gnt0_n   = 1'b0;
            gnt1_n   = 1'b0;
            pv_n     = 1'b1;
            parity_n = acc ^ x_own ^ y_own;
          end
        end
      end
      S_DONE: begin
        last_owner_n = owner_q;
      end
      default: begin
        gnt0_n = 1'b0;
        gnt1_n = 1'b0;
      end
    endcase
  end

  assign bus.gnt0         = gnt0_q;
  assign bus.gnt1         = gnt1_q;
  assign bus.parity       = parity_q;
  assign bus.parity_valid = pv_q;
  assign bus.owner        = owner_q;
  assign bus.abort        = abort_q;

endmodule

// File: tb/tb_parity_acc_arbiter.sv
// Bench for parity_acc_arbiter: directed scenarios then random traffic against a frame-level model.
module tb_parity_acc_arbiter;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 4;
  localparam int TIMEOUT   = 16;
`ifdef PARITY_ACC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  parity_acc_arbiter_if bus();

  parity_acc_arbiter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: counts beats and ones, parity is ones mod 2.
  bit m_busy, m_done;
  int m_own, m_last, m_beats, m_ones, m_stalls;
  bit e_gnt0, e_gnt1, e_par, e_pv, e_owner, e_abort;

  function automatic void model_step();
    bit r, v, x, y, hit;
    if (!reset) begin
      m_busy = 0; m_done = 0; m_last = 1; m_own = 0;
      e_gnt0 = 0; e_gnt1 = 0; e_par = 0; e_pv = 0; e_owner = 0; e_abort = 0;
      return;
    end
    e_pv = 0;
    e_abort = 0;
    if (m_done) begin
      m_done = 0;
      m_last = m_own;
    end else if (!m_busy) begin
      if (bus.req0 || bus.req1) begin
        if (bus.req0 && bus.req1) m_own = 1 - m_last;
        else m_own = bus.req1 ? 1 : 0;
        m_busy = 1; m_beats = 0; m_ones = 0; m_stalls = 0;
        e_gnt0 = (m_own == 0);
        e_gnt1 = (m_own == 1);
        e_owner = (m_own == 1);
      end
    end else begin
      r = (m_own == 1) ? bus.req1 : bus.req0;
      v = (m_own == 1) ? bus.v1 : bus.v0;
      x = (m_own == 1) ? bus.x1 : bus.x0;
      y = (m_own == 1) ? bus.y1 : bus.y0;
      hit = TO_EN && !v && (m_stalls + 1 >= TIMEOUT);
      if (!r || hit) begin
        m_busy = 0; e_gnt0 = 0; e_gnt1 = 0; e_abort = 1; m_last = m_own;
      end else if (v) begin
        m_beats++;
        m_ones = m_ones + int'(x) + int'(y);
        m_stalls = 0;
        if (m_beats == FRAME_LEN) begin
          m_busy = 0; m_done = 1; e_gnt0 = 0; e_gnt1 = 0;
          e_pv = 1; e_par = (m_ones % 2) != 0;
        end
      end else begin
        m_stalls++;
      end
    end
  endfunction

  int pv_cnt = 0, ab_cnt = 0;
  bit pv_par, pv_own, ab_own;
  bit owners[$];
  bit pars[$];

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("gnt0", bus.gnt0, e_gnt0);
    check("gnt1", bus.gnt1, e_gnt1);
    check("parity_valid", bus.parity_valid, e_pv);
    check("parity", bus.parity, e_par);
    check("owner", bus.owner, e_owner);
    check("abort", bus.abort, e_abort);
    check("gnt_excl", bus.gnt0 & bus.gnt1, 0);
    check("pv_abort_excl", bus.parity_valid & bus.abort, 0);
    if (bus.parity_valid) begin
      pv_cnt++; pv_par = bus.parity; pv_own = bus.owner;
      owners.push_back(bus.owner); pars.push_back(bus.parity);
    end
    if (bus.abort) begin
      ab_cnt++; ab_own = bus.owner;
    end
  endtask

  task automatic drive(input int who, input bit r, input bit v, input bit x, input bit y);
    if (who == 0) begin
      bus.req0 = r; bus.v0 = v; bus.x0 = x; bus.y0 = y;
    end else begin
      bus.req1 = r; bus.v1 = v; bus.x1 = x; bus.y1 = y;
    end
  endtask

  // bits[i] is the required x^y of valid beat i.
  task automatic run_frame(input int who, input bit [7:0] bits, input int stall_at, input int nstall);
    bit xb;
    drive(who, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i == stall_at) begin
        drive(who, 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (nstall) tick();
      end
      xb = 1'($urandom_range(0, 1));
      drive(who, 1, 1, xb, xb ^ bits[i]);
      tick();
    end
    drive(who, 0, 0, 0, 0);
    tick();
  endtask

  int pv0, ab0;

  initial begin
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (2) tick();
    check("rst_outs", {bus.gnt0, bus.gnt1, bus.parity, bus.parity_valid, bus.owner, bus.abort}, 0);
    reset = 1'b1;

    // Single frame, x^y pattern 1,0,1,1,0,0,1,0.
    pv0 = pv_cnt;
    run_frame(0, 8'b0100_1101, -1, 0);
    check("s1_pv_count", pv_cnt - pv0, 1);
    check("s1_parity", pv_par, 0);
    check("s1_owner", pv_own, 0);

    // Both requesting continuously: alternation 0,1,0.
    reset = 1'b0; tick(); reset = 1'b1;
    owners.delete(); pars.delete();
    drive(0, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 0);
    repeat (30) tick();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) tick();
    check("s2_results", owners.size(), 3);
    if (owners.size() == 3) begin
      check("s2_owner0", owners[0], 0);
      check("s2_owner1", owners[1], 1);
      check("s2_owner2", owners[2], 0);
      check("s2_par_any", pars[0] | pars[1] | pars[2], 0);
    end

    // Stalls inside a frame are not counted.
    pv0 = pv_cnt;
    run_frame(0, 8'b1001_0110, 3, 4);
    check("s3_parity_even", pv_par, 0);
    run_frame(0, 8'b0001_1111, 5, 2);
    check("s3_parity_odd", pv_par, 1);
    check("s3_pv_count", pv_cnt - pv0, 2);

    // Owner drops req mid-frame; pending req1 takes over.
    pv0 = pv_cnt; ab0 = ab_cnt;
    drive(0, 1, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0);
    repeat (3) begin drive(0, 1, 1, 1, 0); tick(); end
    drive(0, 0, 1, 1, 0); tick();
    check("s4_abort_count", ab_cnt - ab0, 1);
    check("s4_abort_owner", ab_own, 0);
    check("s4_no_pv", pv_cnt - pv0, 0);
    check("s4_parity_kept", bus.parity, 1);
    drive(0, 0, 0, 0, 0);
    tick();
    check("s4_gnt1", bus.gnt1, 1);
    repeat (FRAME_LEN) begin drive(1, 1, 1, 0, 1); tick(); end
    drive(1, 0, 0, 0, 0); tick();
    check("s4_req1_result", pv_cnt - pv0, 1);

    // Reset mid-frame: clean state, no abort, req1 granted afterwards.
    ab0 = ab_cnt;
    drive(0, 1, 0, 0, 0); tick();
    repeat (2) begin drive(0, 1, 1, 1, 0); tick(); end
    reset = 1'b0; tick();
    check("s5_rst_outs", {bus.gnt0, bus.gnt1, bus.parity, bus.parity_valid, bus.owner, bus.abort}, 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0); tick();
    check("s5_gnt1", bus.gnt1, 1);
    check("s5_no_abort", ab_cnt - ab0, 0);
    repeat (FRAME_LEN) begin drive(1, 1, 1, 1, 1); tick(); end
    drive(1, 0, 0, 0, 0); tick();

    // Stalled owner for TIMEOUT edges.
    ab0 = ab_cnt;
    drive(0, 1, 0, 0, 0); tick();
    repeat (TIMEOUT) tick();
    check("s6_abort_count", ab_cnt - ab0, TO_EN ? 1 : 0);
    check("s6_gnt0", bus.gnt0, TO_EN ? 0 : 1);
    drive(0, 0, 0, 0, 0);
    repeat (3) tick();

    // Random traffic.
    reset = 1'b0; tick(); reset = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (bus.req0) bus.req0 = ($urandom_range(0, 39) != 0);
      else          bus.req0 = ($urandom_range(0, 3) == 0);
      if (bus.req1) bus.req1 = ($urandom_range(0, 39) != 0);
      else          bus.req1 = ($urandom_range(0, 3) == 0);
      bus.v0 = ($urandom_range(0, 3) != 0);
      bus.v1 = ($urandom_range(0, 3) != 0);
      bus.x0 = 1'($urandom_range(0, 1)); bus.y0 = 1'($urandom_range(0, 1));
      bus.x1 = 1'($urandom_range(0, 1)); bus.y1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) reset = 1'b0;
      else reset = 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
